axis_join_latency_pipe: RTL and testbench
=========================================

// Module: axis_join_latency_pipe
// PURPOSE
//  Latency-emulating AXI-Stream pipe for two-operand arithmetic cores (FP add/mul stand-ins).
//  Joins operand channels A and B into one beat, carries a user tag, and delivers {B,A} after
//  exactly LATENCY cycles when unstalled. Optional bubble-collapse lets stages advance independently.
//  Sits between the operand schedulers and the result collector in the FP datapath.
// PARAMETERS
//  WIDTH     64  operand width, per channel
//  LATENCY   12  register stages, legal range 1..32; no cap below the parameter
//  USER_W    8   tag width, carried with A
//  COLLAPSE  1   1: per-stage ready, bubbles squeezed out; 0: single global enable for all stages
// PORTS
//  aclk                  in   1            clock
//  aresetn               in   1            reset, synchronous, active-low
//  s_axis_a_tdata        in   WIDTH        operand A
//  s_axis_a_tuser        in   USER_W       tag, travels with the beat
//  s_axis_a_tvalid       in   1            A valid
//  s_axis_a_tready       out  1            A accepted
//  s_axis_b_tdata        in   WIDTH        operand B
//  s_axis_b_tvalid       in   1            B valid
//  s_axis_b_tready       out  1            B accepted
//  m_axis_result_tdata   out  2*WIDTH      {B,A} of the joined beat
//  m_axis_result_tuser   out  USER_W       tag of the joined beat
//  m_axis_result_tvalid  out  1            result valid
//  m_axis_result_tready  in   1            downstream ready
//  occupancy             out  clog2(L+1)   number of valid stages in flight
// BEHAVIOUR
//  - Stages i=0..L-1 each hold v[i], data[i], user[i]. Output comes from stage L-1, with no
//    combinational path from s_* data to m_*.
//  - Reset (aresetn==0 at posedge): all v[i]=0, occupancy=0, m_tvalid=0. Data and user registers
//    are not reset. While aresetn==0, both s_tready=0 (combinational on aresetn).
//  - Reset mid-operation drops all in-flight beats. No beat is emitted after reset.
//  - Stage ready: rdy[L-1] = m_tready | ~v[L-1].
//    COLLAPSE=1: rdy[i] = ~v[i] | rdy[i+1]. COLLAPSE=0: rdy[i] = rdy[L-1] for all i.
//  - Stage i>0 loads {v,data,user} from i-1 when rdy[i]. A stage whose source is empty loads v=0.
//  - Join: fire = a_tvalid & b_tvalid & rdy[0] & aresetn.
//    a_tready = b_tvalid & rdy[0]; b_tready = a_tvalid & rdy[0] (gated by aresetn).
//    A beat is consumed only on fire, and both channels are consumed in the same cycle.
//    A lone valid never completes a handshake.
//  - Stage 0 loads v=fire, data={b,a}, user=a_tuser when rdy[0].
//  - Latency: a beat fired at edge t gives m_tvalid=1 in the cycle after edge t+L-1,
//    i.e. L cycles when unstalled. Throughput is 1 beat/cycle.
//  - Backpressure: with m_tready=0 and v[L-1]=1, stage L-1 holds its data and user stable
//    (AXI rule: no change while valid & ~ready).
//    COLLAPSE=1: upstream stages keep filling until full, so the pipe absorbs up to L beats.
//    COLLAPSE=0: the whole pipe freezes, bubbles included.
//  - Full: all v=1 and m_tready=0 gives rdy[0]=0, so both s_tready=0.
//  - Simultaneous in+out: occupancy += fire - (m_tvalid & m_tready), registered and saturating
//    to neither bound (the handshake rules make overflow and underflow impossible).
//  - Order is strictly FIFO; tags are never reordered or duplicated.
// TESTING
//  1 L=12, m_tready=1, fire A=0x1,B=0x2,tag=0x5 at cycle 0 -> result {0x2,0x1}, tag 0x5
//    valid exactly at cycle 12; occupancy 1 for cycles 1..12.
//  2 A valid only for 5 cycles with B low -> a_tready=0 throughout, no beat, occupancy 0;
//    then B valid -> single fire, both readies 1 that cycle.
//  3 COLLAPSE=1, m_tready=0, stream 20 beats -> exactly 12 accepted, s_tready=0 after,
//    occupancy=12; release -> 20 results in order, tags 0..19.
//  4 COLLAPSE=0, fire at cycles 0 and 5, stall output at cycle 12 for 3 cycles -> gap of 5
//    between results preserved, second result at cycle 20.
//  5 Fill 6 beats, deassert aresetn for 1 cycle -> m_tvalid=0, occupancy=0 next cycle;
//    no stale beat emitted for the following 2L cycles.
//  6 L=1, continuous fire with random m_tready -> no loss/duplication, data held stable
//    while stalled, occupancy never >1.

Source files
------------

// File: rtl/axis_join_latency_pipe.sv
// axis_join_latency_pipe: joins AXI-Stream operands A and B into one {B,A} beat
// and delivers it after LATENCY register stages, with optional bubble collapse.
module axis_join_latency_pipe #(
    parameter int WIDTH    = 64,
    parameter int LATENCY  = 12,
    parameter int USER_W   = 8,
    parameter bit COLLAPSE = 1'b1
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [WIDTH-1:0]                   s_axis_a_tdata,
    input  logic [USER_W-1:0]                  s_axis_a_tuser,
    input  logic                               s_axis_a_tvalid,
    output logic                               s_axis_a_tready,
    input  logic [WIDTH-1:0]                   s_axis_b_tdata,
    input  logic                               s_axis_b_tvalid,
    output logic                               s_axis_b_tready,
    output logic [2*WIDTH-1:0]                 m_axis_result_tdata,
    output logic [USER_W-1:0]                  m_axis_result_tuser,
    output logic                               m_axis_result_tvalid,
    input  logic                               m_axis_result_tready,
    output logic [$clog2(LATENCY+1)-1:0]       occupancy
);

    localparam int OCC_W = $clog2(LATENCY + 1);

    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] rdy;
    logic [2*WIDTH-1:0] data [LATENCY];
    logic [USER_W-1:0]  user [LATENCY];
    logic               fire;
    logic               out_hs;
    logic [OCC_W-1:0]   occ;

    // Stage ready: with collapse a stage may move whenever any stage at or
    // beyond it is empty (or the sink takes the last beat); without collapse
    // every stage follows the output stage so the whole pipe moves together.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        rdy       = '0;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            tail_full = tail_full & v[i];
            if (COLLAPSE) begin
                rdy[i] = m_axis_result_tready | ~tail_full;
            end else begin
                rdy[i] = m_axis_result_tready | ~v[LATENCY-1];
            end
        end
    end

    // Both operands are consumed together, only when stage 0 can take them.
    assign fire = aresetn & s_axis_a_tvalid & s_axis_b_tvalid & rdy[0];

    assign s_axis_a_tready = aresetn & s_axis_b_tvalid & rdy[0];
    assign s_axis_b_tready = aresetn & s_axis_a_tvalid & rdy[0];

    assign out_hs = v[LATENCY-1] & m_axis_result_tready;

    assign m_axis_result_tvalid = v[LATENCY-1];
    assign m_axis_result_tdata  = data[LATENCY-1];
    assign m_axis_result_tuser  = user[LATENCY-1];
    assign occupancy            = occ;

    // Valid bits advance stage by stage; reset drops everything in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= fire;
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                end
            end
        end
    end

    // Payload and tag follow the valid bits; they need no reset.
    always_ff @(posedge aclk) begin
        if (rdy[0]) begin
            data[0] <= {s_axis_b_tdata, s_axis_a_tdata};
            user[0] <= s_axis_a_tuser;
        end
        for (int i = 1; i < LATENCY; i++) begin
            if (rdy[i]) begin
                data[i] <= data[i-1];
                user[i] <= user[i-1];
            end
        end
    end

    // Beats in flight: plus one per join, minus one per delivered result.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(fire) - OCC_W'(out_hs);
        end
    end

endmodule

// File: tb/tb_axis_join_latency_pipe.sv
// Bench for axis_join_latency_pipe: three configurations checked cycle by cycle
// against a queue-based model of beat timing.
module tb_axis_join_latency_pipe;

    localparam int W  = 16;
    localparam int U  = 8;
    localparam int NI = 3;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    logic [W-1:0]   a_data  [NI];
    logic [U-1:0]   a_user  [NI];
    logic           a_valid [NI];
    logic           a_ready [NI];
    logic [W-1:0]   b_data  [NI];
    logic           b_valid [NI];
    logic           b_ready [NI];
    logic [2*W-1:0] r_data  [NI];
    logic [U-1:0]   r_user  [NI];
    logic           r_valid [NI];
    logic           r_ready [NI];
    logic [3:0]     occ_c1;
    logic [3:0]     occ_c0;
    logic [0:0]     occ_l1;

    axis_join_latency_pipe #(
        .WIDTH(W), .LATENCY(12), .USER_W(U), .COLLAPSE(1'b1)
    ) u_c1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_a_tdata(a_data[0]), .s_axis_a_tuser(a_user[0]),
        .s_axis_a_tvalid(a_valid[0]), .s_axis_a_tready(a_ready[0]),
        .s_axis_b_tdata(b_data[0]), .s_axis_b_tvalid(b_valid[0]),
        .s_axis_b_tready(b_ready[0]),
        .m_axis_result_tdata(r_data[0]), .m_axis_result_tuser(r_user[0]),
        .m_axis_result_tvalid(r_valid[0]), .m_axis_result_tready(r_ready[0]),
        .occupancy(occ_c1)
    );

    axis_join_latency_pipe #(
        .WIDTH(W), .LATENCY(12), .USER_W(U), .COLLAPSE(1'b0)
    ) u_c0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_a_tdata(a_data[1]), .s_axis_a_tuser(a_user[1]),
        .s_axis_a_tvalid(a_valid[1]), .s_axis_a_tready(a_ready[1]),
        .s_axis_b_tdata(b_data[1]), .s_axis_b_tvalid(b_valid[1]),
        .s_axis_b_tready(b_ready[1]),
        .m_axis_result_tdata(r_data[1]), .m_axis_result_tuser(r_user[1]),
        .m_axis_result_tvalid(r_valid[1]), .m_axis_result_tready(r_ready[1]),
        .occupancy(occ_c0)
    );

    axis_join_latency_pipe #(
        .WIDTH(W), .LATENCY(1), .USER_W(U), .COLLAPSE(1'b1)
    ) u_l1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_a_tdata(a_data[2]), .s_axis_a_tuser(a_user[2]),
        .s_axis_a_tvalid(a_valid[2]), .s_axis_a_tready(a_ready[2]),
        .s_axis_b_tdata(b_data[2]), .s_axis_b_tvalid(b_valid[2]),
        .s_axis_b_tready(b_ready[2]),
        .m_axis_result_tdata(r_data[2]), .m_axis_result_tuser(r_user[2]),
        .m_axis_result_tvalid(r_valid[2]), .m_axis_result_tready(r_ready[2]),
        .occupancy(occ_l1)
    );

    typedef struct {
        logic [2*W-1:0] d;
        logic [U-1:0]   u;
        int             f;
        int             age;
    } beat_t;

    beat_t q[$];
    int    hs_cyc[$];
    int    cyc;
    int    last_h;
    int    acc_cnt;
    int    n_chk;
    int    n_pass;

    function automatic int lat_of(int k);
        return (k == 2) ? 1 : 12;
    endfunction

    function automatic bit col_of(int k);
        return (k != 1);
    endfunction

    function automatic int occ_of(int k);
        case (k)
            0:       return int'(occ_c1);
            1:       return int'(occ_c0);
            default: return int'(occ_l1);
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock cycle on instance k: drive, check at negedge, advance model.
    task automatic step(int k, bit av, bit bv, bit rr, logic [U-1:0] tag);
        logic [W-1:0] ad;
        logic [W-1:0] bd;
        bit           ev;
        bit           rdy0;
        bit           fire;
        int           lat;
        int           due;
        beat_t        nb;
        lat = lat_of(k);
        ad  = W'($urandom);
        bd  = W'($urandom);
        a_data[k]  = ad;
        b_data[k]  = bd;
        a_user[k]  = tag;
        a_valid[k] = av;
        b_valid[k] = bv;
        r_ready[k] = rr;
        @(negedge aclk);
        ev = 1'b0;
        if (q.size() > 0) begin
            if (col_of(k)) begin
                // a beat shows after L cycles, but never before the cycle
                // following the previous beat's departure
                due = q[0].f + lat;
                if (last_h + 1 > due) due = last_h + 1;
                ev = (cyc >= due);
            end else begin
                // frozen pipe: a beat ages only on cycles the pipe moves
                ev = (q[0].age == lat - 1);
            end
        end
        if (col_of(k)) rdy0 = rr || (q.size() < lat);
        else           rdy0 = rr || !ev;
        fire = av && bv && rdy0;
        chk("a_tready", a_ready[k], bv && rdy0);
        chk("b_tready", b_ready[k], av && rdy0);
        chk("m_tvalid", r_valid[k], ev);
        chk("occupancy", occ_of(k), q.size());
        if (ev) begin
            chk("m_tdata", r_data[k], q[0].d);
            chk("m_tuser", r_user[k], q[0].u);
        end
        if (r_valid[k] && rr) hs_cyc.push_back(cyc);
        if (av && bv && a_ready[k] && b_ready[k]) acc_cnt++;
        if (ev && rr) begin
            void'(q.pop_front());
            last_h = cyc;
        end
        if (!col_of(k) && (rr || !ev)) begin
            foreach (q[i]) q[i].age++;
        end
        if (fire) begin
            nb.d   = {bd, ad};
            nb.u   = tag;
            nb.f   = cyc;
            nb.age = 0;
            q.push_back(nb);
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    // One reset cycle with both valids high on instance k.
    task automatic do_reset(int k);
        a_valid[k] = 1'b1;
        b_valid[k] = 1'b1;
        r_ready[k] = 1'b1;
        aresetn    = 1'b0;
        @(negedge aclk);
        chk("rst_a_tready", a_ready[k], 1'b0);
        chk("rst_b_tready", b_ready[k], 1'b0);
        @(posedge aclk);
        #1;
        aresetn    = 1'b1;
        a_valid[k] = 1'b0;
        b_valid[k] = 1'b0;
        q.delete();
        hs_cyc.delete();
        last_h  = -100;
        cyc     = 0;
        acc_cnt = 0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        cyc     = 0;
        last_h  = -100;
        acc_cnt = 0;
        aresetn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            a_data[k]  = '0;
            a_user[k]  = '0;
            a_valid[k] = 1'b0;
            b_data[k]  = '0;
            b_valid[k] = 1'b0;
            r_ready[k] = 1'b0;
        end
        repeat (3) @(posedge aclk);
        #1;

        // single beat latency
        do_reset(0);
        a_user[0] = 8'h05;
        a_data[0] = 16'h1;
        step(0, 1'b1, 1'b1, 1'b1, 8'h05);
        for (int t = 0; t < 14; t++) step(0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("t1_results", hs_cyc.size(), 1);
        if (hs_cyc.size() > 0) chk("t1_latency", hs_cyc[0], 12);

        // lone A valid never handshakes, then join
        do_reset(0);
        for (int t = 0; t < 5; t++) step(0, 1'b1, 1'b0, 1'b1, 8'h11);
        chk("t2_no_accept", acc_cnt, 0);
        step(0, 1'b1, 1'b1, 1'b1, 8'h22);
        step(0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("t2_one_accept", acc_cnt, 1);
        for (int t = 0; t < 12; t++) step(0, 1'b0, 1'b0, 1'b1, 8'h00);

        // collapse pipe absorbs exactly L beats under stall
        do_reset(0);
        for (int t = 0; t < 20; t++) step(0, 1'b1, 1'b1, 1'b0, U'(t));
        chk("t3_accepted", acc_cnt, 12);
        chk("t3_occ_full", occ_c1, 12);
        for (int t = 0; t < 40; t++) begin
            step(0, 1'b1, 1'b1, 1'b1, U'(acc_cnt));
            if (acc_cnt >= 20) begin
                a_valid[0] = 1'b0;
                b_valid[0] = 1'b0;
                break;
            end
        end
        for (int t = 0; t < 30; t++) step(0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("t3_results", hs_cyc.size(), 20);

        // frozen pipe keeps the gap between beats
        do_reset(1);
        for (int t = 0; t < 30; t++) begin
            step(1, (t == 0 || t == 5), (t == 0 || t == 5),
                 !(t >= 12 && t <= 14), U'(t));
        end
        chk("t4_results", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2) begin
            chk("t4_second", hs_cyc[1], 20);
            chk("t4_gap", hs_cyc[1] - hs_cyc[0], 5);
        end

        // reset mid-flight drops everything
        do_reset(0);
        for (int t = 0; t < 6; t++) step(0, 1'b1, 1'b1, 1'b0, U'(t));
        chk("t5_filled", occ_c1, 6);
        do_reset(0);
        for (int t = 0; t < 24; t++) step(0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("t5_no_stale", hs_cyc.size(), 0);

        // L=1 with random backpressure
        do_reset(2);
        for (int t = 0; t < 200; t++) begin
            step(2, ($urandom_range(7) != 0), ($urandom_range(7) != 0),
                 $urandom_range(1) == 1, U'($urandom));
        end

        // random traffic on both L=12 variants
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            for (int t = 0; t < 300; t++) begin
                step(k, ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                     ($urandom_range(4) > 1), U'($urandom));
            end
            a_valid[k] = 1'b0;
            b_valid[k] = 1'b0;
            for (int t = 0; t < 30; t++) step(k, 1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_empty", q.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
